fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised instruction-fetch front end for the WISC core. Owns the PC,
//  issues requests to instruction memory over a valid/ready handshake, buffers
//  responses in a DEPTH-entry prefetch FIFO and delivers {instr, pc} to decode.
//  Supports branch redirect/flush and sticky halt on the HLT opcode.
// PARAMETERS
//  DWIDTH   16       instruction width (bits)
//  AWIDTH   16       address/PC width (bits)
//  DEPTH    4        prefetch FIFO entries; also the outstanding-request limit (>=2)
//  RESET_PC 16'h0000 PC value loaded on reset
//  PC_INC   2        byte increment per sequential fetch
// PORTS
//  clk            in  1       clock, all state on rising edge
//  rst            in  1       asynchronous, active-low reset
//  imem_req_valid out 1       fetch request valid
//  imem_req_ready in  1       memory accepts request this cycle
//  imem_addr      out AWIDTH  fetch address, stable while valid && !ready
//  imem_rsp_valid in  1       in-order response valid; never back-pressured
//  imem_rsp_data  in  DWIDTH  response instruction word
//  instr_valid    out 1       FIFO head valid to decode
//  instr_ready    in  1       decode accepts head
//  instr          out DWIDTH  head instruction
//  instr_pc       out AWIDTH  address of head instruction
//  redirect       in  1       branch taken / flush
//  redirect_pc    in  AWIDTH  new fetch PC
//  hlt            out 1       sticky halt flag
//  pc             out AWIDTH  next address to be requested
//  perf_fetch_cnt out 32      accepted requests (FETCH_PERF_EN)
//  perf_flush_cnt out 32      redirects taken (FETCH_PERF_EN)
// BEHAVIOUR
//  - Reset: pc=RESET_PC, FIFO empty, outstanding=0, drop=0, hlt=0; all valids 0.
//  - Issue: req_valid = !hlt && !redirect && (occupancy+outstanding < DEPTH).
//    Request handshake: pc += PC_INC (mod 2^AWIDTH, wraps silently), outstanding++.
//  - Response: outstanding--; if drop>0 then drop-- and discard, else push
//    {data, tag PC} into FIFO. Tag PCs are kept in a per-request queue, same depth.
//  - Delivery: instr_valid the cycle after push at earliest (registered FIFO);
//    pop on instr_valid && instr_ready. Credit check guarantees no overflow.
//  - Redirect (cycle N): FIFO flushed, pc<=redirect_pc, drop<=outstanding
//    minus any response arriving in cycle N, pending un-accepted request withdrawn.
//    First request to redirect_pc at N+1. Same-cycle response is discarded.
//  - Redirect + instr handshake same cycle: handshake counts (decode has item),
//    then flush applies. Back-to-back redirects: latest redirect_pc wins; drop
//    accumulates correctly.
//  - Halt: on instr handshake with instr[DWIDTH-1:DWIDTH-4]==HLT_OP, hlt<=1 next
//    cycle; FIFO flushed, no further requests, redirects ignored, pc frozen;
//    in-flight responses drained and dropped. Cleared only by reset.
//  - Reset mid-operation: immediate return to reset state; responses from
//    pre-reset requests are the memory's responsibility (it is reset too).
//  - Simultaneous push+pop at full or empty handled; occupancy unchanged.
// CONFIGURATION
//  FETCH_PERF_EN defined: two 32-bit saturating counters, reset 0; fetch_cnt
//    increments per request handshake, flush_cnt per redirect accepted while !hlt.
//  FETCH_PERF_EN undefined: counters not built, perf_* ports tied to 0.
// STRUCTURE
//  - Shared package wisc_pkg: HLT_OP (4'hF), RESET_PC default, DWIDTH/AWIDTH
//    defaults, clog2 helper for counter widths.
//  - One sub-module: fetch_fifo (parametric DEPTH x (DWIDTH+AWIDTH) sync FIFO,
//    flush input, count output); PC/credit/drop logic in fetch_unit.
// TESTING
//  1 Reset, ready=1, 1-cycle mem: addrs 0,2,4,6..., instr_pc matches, no gaps.
//  2 instr_ready=0, DEPTH=4: exactly 4 requests then req_valid=0 until a pop.
//  3 2 requests outstanding, redirect_pc=16'h0100: both responses dropped,
//    next req addr=0x0100, first delivered instr_pc=0x0100.
//  4 Redirect same cycle as response and instr handshake: response dropped,
//    handshake item consumed, FIFO empty at N+1.
//  5 Deliver 16'hF000 with instr_ready=1: hlt=1 next cycle, req_valid stays 0,
//    later redirect ignored, pc frozen.
//  6 pc=16'hFFFE sequential fetch: next addr 0x0000; FETCH_PERF_EN build shows
//    fetch_cnt/flush_cnt match counts, undefined build shows 0.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC front end: default widths, the halt opcode,
// the reset PC and small helpers used to size and update counters.
package wisc_pkg;

  localparam int DWIDTH_DEF = 16;
  localparam int AWIDTH_DEF = 16;
  localparam logic [3:0]  HLT_OP       = 4'hF;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

  typedef logic [31:0] perf_cnt_t;

  // Smallest r such that 2**r >= value (at least 1 so widths never collapse).
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic perf_cnt_t sat_inc(input perf_cnt_t value);
    return (value == '1) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with a flush input and an occupancy count.
// The head word is read straight from the storage registers, so an entry
// pushed on one edge is visible at the output from the next cycle on.
// Push while full is accepted only when a pop happens in the same cycle.
module fetch_fifo
  import wisc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          head,
  output logic                      head_valid,
  output logic [clog2(DEPTH+1)-1:0] count
);

  localparam int CW = clog2(DEPTH + 1);
  localparam int PW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && !flush && ((count_reg != CW'(DEPTH)) || do_pop);

  // Next pointer/count values; a flush empties the queue outright.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (do_push) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
      count_next = count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage: each entry captures the push word when the write pointer selects it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (do_push && (wr_ptr_reg == PW'(gi))) begin
        mem_reg[gi] <= push_data;
      end
    end
  end

  assign head       = mem_reg[rd_ptr_reg];
  assign head_valid = (count_reg != '0);
  assign count      = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// WISC instruction-fetch front end. Owns the PC, issues requests to
// instruction memory, keeps one tag (request PC) per outstanding request,
// buffers responses in a prefetch FIFO and hands {instr, pc} to decode.
// Redirects flush the FIFO and mark all still-outstanding responses for
// discard; fetching the halt opcode freezes the unit until reset.
// Optional build macro: FETCH_PERF_EN adds saturating request/redirect
// counters on perf_fetch_cnt/perf_flush_cnt (tied to zero otherwise).
module fetch_unit
  import wisc_pkg::*;
#(
  parameter int                DWIDTH   = DWIDTH_DEF,
  parameter int                AWIDTH   = AWIDTH_DEF,
  parameter int                DEPTH    = 4,
  parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(RESET_PC_DEF),
  parameter int                PC_INC   = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [AWIDTH-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [DWIDTH-1:0] imem_rsp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DWIDTH-1:0] instr,
  output logic [AWIDTH-1:0] instr_pc,
  input  logic              redirect,
  input  logic [AWIDTH-1:0] redirect_pc,
  output logic              hlt,
  output logic [AWIDTH-1:0] pc,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_flush_cnt
);

  localparam int CW = clog2(DEPTH + 1);
  localparam int EW = DWIDTH + AWIDTH;

  logic [AWIDTH-1:0] pc_reg, pc_next;
  logic [CW-1:0]     drop_reg, drop_next;
  logic              hlt_reg, hlt_next;

  logic [CW-1:0]     occupancy;
  logic [CW-1:0]     outstanding;
  logic [CW:0]       in_use;
  logic              credit_ok;
  logic [EW-1:0]     fifo_head;
  logic              fifo_valid;
  logic [AWIDTH-1:0] tag_head;
  logic              tag_valid;

  logic req_fire;
  logic rsp_ok;
  logic rsp_keep;
  logic deliver;
  logic redirect_take;
  logic halt_take;
  logic flush;

  // Slots already committed: buffered entries plus responses still owed.
  assign in_use    = {1'b0, occupancy} + {1'b0, outstanding};
  assign credit_ok = in_use < (CW + 1)'(DEPTH);

  // Request is held low while reset is asserted and during a redirect cycle.
  assign imem_req_valid = rst && !hlt_reg && !redirect && credit_ok;
  assign imem_addr      = pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with no matching tag cannot belong to us and is ignored.
  assign rsp_ok   = imem_rsp_valid && tag_valid;

  assign instr       = fifo_head[AWIDTH +: DWIDTH];
  assign instr_pc    = fifo_head[AWIDTH-1:0];
  assign instr_valid = fifo_valid;
  assign deliver     = fifo_valid && instr_ready;

  assign redirect_take = redirect && !hlt_reg;
  assign halt_take     = deliver && (instr[DWIDTH-1 -: 4] == HLT_OP) && !hlt_reg;
  assign flush         = redirect_take || halt_take;

  // Keep a response only if nothing older than the last redirect is owed,
  // the unit is running and no flush is happening this cycle.
  assign rsp_keep = rsp_ok && (drop_reg == '0) && !hlt_reg && !flush;

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_data_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push       (rsp_keep),
    .push_data  ({imem_rsp_data, tag_head}),
    .pop        (deliver),
    .head       (fifo_head),
    .head_valid (fifo_valid),
    .count      (occupancy)
  );

  // Tag queue: one PC per accepted request, consumed by every response
  // (kept or dropped), so its count is the outstanding-request count.
  fetch_fifo #(
    .WIDTH (AWIDTH),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (1'b0),
    .push       (req_fire),
    .push_data  (pc_reg),
    .pop        (rsp_ok),
    .head       (tag_head),
    .head_valid (tag_valid),
    .count      (outstanding)
  );

  // Next PC, discard count and halt flag.
  always_comb begin
    pc_next   = pc_reg;
    drop_next = drop_reg;
    hlt_next  = hlt_reg | halt_take;
    if (redirect_take) begin
      pc_next = redirect_pc;
    end else if (req_fire) begin
      pc_next = pc_reg + AWIDTH'(PC_INC);
    end
    if (redirect_take) begin
      // Everything still owed after this cycle belongs to the old stream.
      drop_next = outstanding - CW'(rsp_ok);
    end else if (rsp_ok && (drop_reg != '0)) begin
      drop_next = drop_reg - 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg   <= RESET_PC;
      drop_reg <= '0;
      hlt_reg  <= 1'b0;
    end else begin
      pc_reg   <= pc_next;
      drop_reg <= drop_next;
      hlt_reg  <= hlt_next;
    end
  end

  assign pc  = pc_reg;
  assign hlt = hlt_reg;

`ifdef FETCH_PERF_EN
  perf_cnt_t fetch_cnt_reg;
  perf_cnt_t flush_cnt_reg;

  // Saturating counts of accepted requests and accepted redirects.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (req_fire)      fetch_cnt_reg <= sat_inc(fetch_cnt_reg);
      if (redirect_take) flush_cnt_reg <= sat_inc(flush_cnt_reg);
    end
  end

  assign perf_fetch_cnt = fetch_cnt_reg;
  assign perf_flush_cnt = flush_cnt_reg;
`else
  assign perf_fetch_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an in-order memory with random latency, random
// ready/decode back-pressure and redirects, checked against a stream model
// (expected request PC, delivered-item queue, epochs for stale responses).
module tb_fetch_unit;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [AW-1:0] imem_addr;
  logic          imem_rsp_valid;
  logic [DW-1:0] imem_rsp_data;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          hlt;
  logic [AW-1:0] pc;
  logic [31:0]   perf_fetch_cnt;
  logic [31:0]   perf_flush_cnt;

  fetch_unit #(
    .DWIDTH   (DW),
    .AWIDTH   (AW),
    .DEPTH    (DEPTH),
    .RESET_PC (16'h0000),
    .PC_INC   (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .hlt            (hlt),
    .pc             (pc),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          epoch;
    int          due;
  } mreq_t;

  typedef struct {
    logic [15:0] data;
    logic [15:0] pc;
  } item_t;

  mreq_t mem_q[$];
  item_t model_q[$];

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          epoch = 0;
  int          last_due = 0;
  int          lat_lo = 0;
  int          lat_hi = 0;
  int          fire_m = 0;
  int          flush_m = 0;
  logic [15:0] exp_req = 16'h0000;
  bit          hlt_m = 1'b0;
  bit          hlt_en = 1'b0;
  logic [15:0] hlt_addr = 16'h0000;

  bit          obs_fire;
  logic [15:0] obs_addr;
  bit          obs_deliv;
  logic [15:0] obs_dpc;
  bit          obs_ivalid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [14:0] mix;
    if (hlt_en && (a == hlt_addr)) return 16'hF000;
    mix = a[14:0] ^ 15'h2A5B;
    return {1'b0, mix};
  endfunction

  task automatic chk_perf();
`ifdef FETCH_PERF_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, 32'(fire_m));
    chk("perf_flush_cnt", perf_flush_cnt, 32'(flush_m));
`else
    chk("perf_fetch_cnt", perf_fetch_cnt, 32'd0);
    chk("perf_flush_cnt", perf_flush_cnt, 32'd0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 16'h0000;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 16'h0000;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_hlt", 32'(hlt), 32'd0);
    chk("rst_pc", 32'(pc), 32'h0000);
    chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
    chk("rst_perf_flush", perf_flush_cnt, 32'd0);
    mem_q.delete();
    model_q.delete();
    epoch    = 0;
    exp_req  = 16'h0000;
    hlt_m    = 1'b0;
    last_due = 0;
    fire_m   = 0;
    flush_m  = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model by the events that the coming rising edge commits.
  task automatic step(input bit rdy, input bit irdy, input bit redir, input logic [15:0] rpc);
    item_t it;
    mreq_t m;
    bit    exp_rv;
    bit    rsp_now;
    bit    halting;
    int    lat;
    @(negedge clk);
    rsp_now        = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_req_ready = rdy;
    instr_ready    = irdy;
    redirect       = redir;
    redirect_pc    = rpc;
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_q[0].data : 16'h0000;
    #1;
    exp_rv = !hlt_m && !redir && ((model_q.size() + mem_q.size()) < DEPTH);
    chk("hlt", 32'(hlt), 32'(hlt_m));
    chk("instr_valid", 32'(instr_valid), 32'(model_q.size() != 0));
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    chk("pc", 32'(pc), 32'(exp_req));
    if (exp_rv) chk("imem_addr", 32'(imem_addr), 32'(exp_req));

    obs_fire   = imem_req_valid && rdy;
    obs_addr   = imem_addr;
    obs_ivalid = instr_valid;
    obs_deliv  = instr_valid && irdy;
    obs_dpc    = instr_pc;
    halting    = 1'b0;

    if (obs_deliv && (model_q.size() > 0)) begin
      it = model_q.pop_front();
      chk("instr", 32'(instr), 32'(it.data));
      chk("instr_pc", 32'(instr_pc), 32'(it.pc));
      halting = (it.data[15:12] == 4'hF);
    end
    if (rsp_now) begin
      m = mem_q.pop_front();
      if ((m.epoch == epoch) && !hlt_m && !redir) begin
        it.data = m.data;
        it.pc   = m.addr;
        model_q.push_back(it);
      end
    end
    if (redir && !hlt_m) begin
      model_q.delete();
      epoch++;
      exp_req = rpc;
      flush_m++;
    end
    if (halting) begin
      model_q.delete();
      hlt_m = 1'b1;
    end
    if (exp_rv && rdy) begin
      fire_m++;
      exp_req = exp_req + 16'd2;
    end
    if (obs_fire) begin
      lat     = int'($urandom_range(lat_hi, lat_lo));
      m.addr  = imem_addr;
      m.data  = mem_word(imem_addr);
      m.epoch = epoch;
      m.due   = cyc + 1 + lat;
      if (m.due < last_due) m.due = last_due;
      last_due = m.due;
      mem_q.push_back(m);
    end
    cyc++;
  endtask

  initial begin
    int          n;
    int          n_deliv;
    bit          seen;
    logic [15:0] first_pc;
    logic [15:0] frozen_pc;
    logic [15:0] prev_addr;
    logic [15:0] rpc;
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 16'h0000;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 16'h0000;

    // Sequential fetch with a 1-cycle memory: continuous delivery.
    lat_lo = 0; lat_hi = 0;
    do_reset();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'h0000);
      if (obs_deliv) n++;
    end
    chk("t1_deliveries", 32'(n), 32'd18);

    // Decode stalled: credit limit stops requests at DEPTH.
    do_reset();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'h0000);
      if (obs_fire) n++;
    end
    chk("t2_fires_full", 32'(n), 32'd4);
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    if (obs_fire) n++;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'h0000);
      if (obs_fire) n++;
    end
    chk("t2_fires_after_pop", 32'(n), 32'd5);

    // Redirect with two requests outstanding.
    lat_lo = 2; lat_hi = 2;
    do_reset();
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b1, 16'h0100);
    seen = 1'b0;
    first_pc = 16'hDEAD;
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'h0000);
      if (obs_deliv && !seen) begin
        seen = 1'b1;
        first_pc = obs_dpc;
      end
      if (i == 0) chk("t3_first_req", 32'(obs_addr), 32'h0100);
    end
    chk("t3_first_deliv_pc", 32'(first_pc), 32'h0100);

    // Redirect in the same cycle as a response and a decode handshake.
    lat_lo = 0; lat_hi = 0;
    do_reset();
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b1, 16'h0200);
    chk("t4_item_at_N", 32'(obs_ivalid), 32'd1);
    chk("t4_item_pc", 32'(obs_dpc), 32'h0000);
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("t4_empty_N1", 32'(obs_ivalid), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 16'h0000);

    // Halt opcode at address 4.
    hlt_en = 1'b1; hlt_addr = 16'h0004;
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("t5_hlt", 32'(hlt), 32'd1);
    frozen_pc = exp_req;
    step(1'b1, 1'b1, 1'b1, 16'h0300);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("t5_pc_frozen", 32'(pc), 32'(frozen_pc));
    chk("t5_req_valid", 32'(imem_req_valid), 32'd0);
    hlt_en = 1'b0;

    // Wrap of the PC past 16'hFFFE, then counter check.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 16'hFFFC);
    seen = 1'b0;
    prev_addr = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'h0000);
      if (obs_fire) begin
        if ((obs_addr == 16'h0000) && (prev_addr == 16'hFFFE)) seen = 1'b1;
        prev_addr = obs_addr;
      end
    end
    chk("t6_wrap", 32'(seen), 32'd1);
    chk_perf();

    // Random traffic, with a reset in the middle.
    lat_lo = 0; lat_hi = 3;
    n_deliv = 0;
    for (int phase = 0; phase < 2; phase++) begin
      do_reset();
      for (int i = 0; i < 1500; i++) begin
        rpc = 16'($urandom) & 16'hFFFE;
        if ($urandom_range(3, 0) == 0) rpc = 16'hFFFA;
        step($urandom_range(3, 0) != 0, $urandom_range(9, 0) < 7,
             $urandom_range(29, 0) == 0, rpc);
        if (obs_deliv) n_deliv++;
      end
      chk_perf();
    end
    chk("rand_progress", 32'(n_deliv > 500), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
